seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Sequencer for the single-bit Moore sequence detector (pattern "101", overlapping, output high in S3).
//  Accepts a parallel word over a valid/ready handshake and serialises it MSB-first into the detector.
//  Holds the detector in reset between words and counts detector hits, saturating at the counter maximum.
//  Returns the hit count over a valid/ready handshake. The detector is external; this block drives its in/rst and samples its out.
// PARAMETERS
//  WIDTH  8  bits per word; >= 2
//  CNT_W  4  hit counter width; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-low reset
//  in_valid   in   1      word available
//  in_ready   out  1      block can accept a word
//  in_data    in   WIDTH  word; bit WIDTH-1 is sent first
//  det_rst    out  1      detector reset, active-high, registered
//  det_in     out  1      serial bit to detector, registered
//  det_out    in   1      detector Moore output
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  out_hits   out  CNT_W  hits in the last word
//  out_sat    out  1      hit counter saturated during the last word
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, det_rst=1, det_in=0, out_valid=0, out_hits=0, out_sat=0.
//  in_ready is high only in IDLE. out_valid is high only in DONE. All outputs come straight from registers.
//  FSM:
//   IDLE : det_rst=1. If in_valid, accept in_data into the shift register, load bit_cnt=WIDTH-1,
//          and clear hits/sat. Next state: SHIFT.
//   SHIFT: det_rst=0. det_in=shreg[WIDTH-1], then shift left by 1 each cycle (exactly one bit per cycle).
//          When bit_cnt==0, go to DRAIN; otherwise decrement bit_cnt.
//   DRAIN: det_rst=0, det_in=0. Exactly one cycle; lets the last bit's result appear on det_out. Next state: DONE.
//   DONE : det_rst=1, det_in=0, out_valid=1; out_hits/out_sat held stable.
//          If out_ready, go to IDLE. There is no IDLE-bypass: a new word can be accepted no earlier
//          than the cycle after the result handshake.
//  Sampling:
//   - 1-cycle flag samp = "a bit was driven last cycle". It is high in the cycle after each SHIFT cycle
//     (SHIFT cycles 2..WIDTH, then DRAIN); otherwise 0.
//   - When samp && det_out: if hits != max, hits+1; else out_sat=1 and hits holds at max.
//   - det_out is ignored whenever samp=0, including the whole reset-held interval.
//  Timing: accept on edge t0 -> SHIFT covers cycles t0..t0+WIDTH-1 -> DRAIN at t0+WIDTH ->
//   out_valid first high at t0+WIDTH+1. Minimum word period is WIDTH+3 cycles.
//  Detector state never carries across words: every word starts from S0.
//  Reset asserted mid-word aborts the word immediately: state=IDLE, det_rst=1, and the result is lost.
//  in_valid during SHIFT/DRAIN/DONE is ignored (in_ready=0); in_data is only sampled at accept.
//  Arithmetic: hits is unsigned CNT_W bits and never wraps. out_hits = hits register.
// TESTING (bench instantiates the codebase "101" Moore detector; WIDTH=8, CNT_W=4 unless noted)
//  1) in_data=8'b10111011, out_ready=1 -> det_in sequence 1,0,1,1,1,0,1,1; out_hits=2, out_sat=0;
//     out_valid exactly 9 cycles after accept.
//  2) in_data=8'hAA -> out_hits=3; then in_data=8'h00 back-to-back -> out_hits=0
//     (proves detector was reset between words).
//  3) CNT_W=1, in_data=8'hAA -> out_hits=1, out_sat=1.
//  4) out_ready=0 for 5 cycles in DONE -> out_valid/out_hits stable, in_ready=0, det_rst=1;
//     in_valid pulses during this time are ignored.
//  5) rst low during SHIFT, bit 4 of 8'hAA -> all outputs at reset values asynchronously;
//     next word 8'b00000101 -> out_hits=1.
//  6) in_valid held high continuously with a different word each accept -> one result per word,
//     word period = 11 cycles, no word dropped or duplicated.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Handshake and detector-side signal bundle for seq_detect_ctrl.
// The slave modport is the controller's view. The master modport is the environment's view.
interface seq_detect_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             det_rst;
  logic             det_in;
  logic             det_out;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_hits;
  logic             out_sat;

  modport slave (
    input  in_valid, in_data, det_out, out_ready,
    output in_ready, det_rst, det_in, out_valid, out_hits, out_sat
  );

  modport master (
    output in_valid, in_data, det_out, out_ready,
    input  in_ready, det_rst, det_in, out_valid, out_hits, out_sat
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serialises a parallel word MSB-first into an external "101" Moore detector.
// It holds the detector in reset between words and returns the saturating hit count.
module seq_detect_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_ctrl_if.slave  bus
);

  localparam int CNT_BW = $clog2(WIDTH);
  localparam logic [CNT_BW-1:0] LAST = CNT_BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  HITS_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [WIDTH-1:0]  shreg;
  logic [CNT_BW-1:0] bit_cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              det_rst_q;
  logic              det_in_q;
  logic              samp;
  logic [CNT_W-1:0]  hits;
  logic              sat;
  logic              accept;

  // Returns {sat, hits} after one detector hit. The count sticks at its maximum.
  function automatic logic [CNT_W:0] count_hit(input logic [CNT_W-1:0] h, input logic s);
    if (h == HITS_MAX) return {1'b1, h};
    else               return {s, h + CNT_W'(1)};
  endfunction

  assign accept = (state == S_IDLE) && bus.in_valid;

  // The MSB goes onto det_in at the accept edge, so every SHIFT cycle already drives a bit.
  // Its detector result is therefore visible one cycle later, while samp is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      det_rst_q   <= 1'b1;
      det_in_q    <= 1'b0;
      samp        <= 1'b0;
      hits        <= '0;
      sat         <= 1'b0;
    end else begin
      samp <= (state == S_SHIFT);
      if (samp && bus.det_out) {sat, hits} <= count_hit(hits, sat);
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            state      <= S_SHIFT;
            in_ready_q <= 1'b0;
            det_rst_q  <= 1'b0;
            det_in_q   <= bus.in_data[WIDTH-1];
            hits       <= '0;
            sat        <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (bit_cnt == '0) begin
            state    <= S_DRAIN;
            det_in_q <= 1'b0;
          end else begin
            det_in_q <= shreg[WIDTH-1];
          end
        end
        S_DRAIN: begin
          state       <= S_DONE;
          det_rst_q   <= 1'b1;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          det_rst_q   <= 1'b1;
          det_in_q    <= 1'b0;
        end
      endcase
    end
  end

  // The shift register holds the bits still to be sent. It carries no reset because it is only read in SHIFT.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= bus.in_data << 1;
      bit_cnt <= LAST;
    end else if (state == S_SHIFT) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.det_rst   = det_rst_q;
  assign bus.det_in    = det_in_q;
  assign bus.out_hits  = hits;
  assign bus.out_sat   = sat;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl. Two instances are used (CNT_W=4 and CNT_W=1), each driving a behavioural "101" Moore detector.
// Expected counts come from counting overlapping "101" substrings of each word.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.WIDTH(8), .CNT_W(4)) if4 ();
  seq_detect_ctrl_if #(.WIDTH(8), .CNT_W(1)) if1 ();

  seq_detect_ctrl #(.WIDTH(8), .CNT_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_detect_ctrl #(.WIDTH(8), .CNT_W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // External detector: S0..S3, output high in S3, synchronous reset on det_rst
  logic [1:0] det4_st = 2'd0;
  logic [1:0] det1_st = 2'd0;

  function automatic logic [1:0] det_next(input logic [1:0] st, input logic b);
    case (st)
      2'd0:    return b ? 2'd1 : 2'd0;
      2'd1:    return b ? 2'd1 : 2'd2;
      2'd2:    return b ? 2'd3 : 2'd0;
      default: return b ? 2'd1 : 2'd2;
    endcase
  endfunction

  always @(posedge clk) begin
    det4_st <= if4.det_rst ? 2'd0 : det_next(det4_st, if4.det_in);
    det1_st <= if1.det_rst ? 2'd0 : det_next(det1_st, if1.det_in);
  end

  assign if4.det_out = (det4_st == 2'd3);
  assign if1.det_out = (det1_st == 2'd3);

  // Reference model: number of overlapping "101" occurrences, scanned MSB first.
  function automatic int count_101(input logic [7:0] w);
    int c = 0;
    for (int i = 7; i >= 2; i--)
      if (w[i] && !w[i-1] && w[i-2]) c++;
    return c;
  endfunction

  function automatic int exp_hits(input logic [7:0] w, input int cw);
    int mx = (1 << cw) - 1;
    int c  = count_101(w);
    return (c > mx) ? mx : c;
  endfunction

  function automatic logic exp_sat(input logic [7:0] w, input int cw);
    return count_101(w) > ((1 << cw) - 1);
  endfunction

  // Sends one word to the CNT_W=4 instance and records what it produced. It starts and ends at posedge+1.
  task automatic run_word4(input logic [7:0] w, output int lat, output logic [3:0] h,
                           output logic s, output logic [7:0] bits, output logic to);
    int   n;
    logic rdy;
    to = 1'b0; lat = 0; bits = '0; h = '0; s = 1'b0; n = 0;
    if4.in_data  = w;
    if4.in_valid = 1'b1;
    do begin
      rdy = if4.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 40);
    if4.in_valid = 1'b0;
    if (!rdy) begin
      to = 1'b1;
      return;
    end
    while (!if4.out_valid && lat < 40) begin
      if (lat < 8) bits[7-lat] = if4.det_in;
      @(posedge clk); #1;
      lat++;
    end
    if (!if4.out_valid) to = 1'b1;
    h = if4.out_hits;
    s = if4.out_sat;
    if (if4.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    n_checks++; if (if4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", if4.in_ready); end
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", if4.out_valid); end
    n_checks++; if (if4.det_rst !== 1'b1)   begin n_fail++; $display("FAIL reset_det_rst got %b want 1", if4.det_rst); end
    n_checks++; if (if4.det_in !== 1'b0)    begin n_fail++; $display("FAIL reset_det_in got %b want 0", if4.det_in); end
    n_checks++; if (if4.out_hits !== 4'd0)  begin n_fail++; $display("FAIL reset_out_hits got %0d want 0", if4.out_hits); end
    n_checks++; if (if4.out_sat !== 1'b0)   begin n_fail++; $display("FAIL reset_out_sat got %b want 0", if4.out_sat); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat; logic [3:0] h; logic s; logic [7:0] bits; logic to;
    run_word4(8'b10111011, lat, h, s, bits, to);
    n_checks++; if (to !== 1'b0)           begin n_fail++; $display("FAIL basic_timeout got %b want 0", to); end
    n_checks++; if (bits !== 8'b10111011)  begin n_fail++; $display("FAIL basic_det_in_seq got %b want 10111011", bits); end
    n_checks++; if (lat != 9)              begin n_fail++; $display("FAIL basic_latency got %0d want 9", lat); end
    n_checks++; if (h !== 4'd2)            begin n_fail++; $display("FAIL basic_hits got %0d want 2", h); end
    n_checks++; if (s !== 1'b0)            begin n_fail++; $display("FAIL basic_sat got %b want 0", s); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3];
    int lat; logic [3:0] h; logic s; logic [7:0] bits; logic to;
    words[0] = 8'hAA; words[1] = 8'h00; words[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      run_word4(words[i], lat, h, s, bits, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout word %0d got %b want 0", i, to); end
      n_checks++; if (h !== 4'(exp_hits(words[i], 4)))
        begin n_fail++; $display("FAIL b2b_hits word %h got %0d want %0d", words[i], h, exp_hits(words[i], 4)); end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] words [3];
    int   n;
    logic rdy;
    words[0] = 8'hAA; words[1] = 8'h80; words[2] = 8'hA0;
    for (int i = 0; i < 3; i++) begin
      if1.in_data  = words[i];
      if1.in_valid = 1'b1;
      n = 0;
      do begin
        rdy = if1.in_ready;
        @(posedge clk); #1;
        n++;
      end while (!rdy && n < 40);
      if1.in_valid = 1'b0;
      n = 0;
      while (!if1.out_valid && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      n_checks++; if (if1.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_timeout word %h got %b want 1", words[i], if1.out_valid); end
      n_checks++; if (if1.out_hits !== 1'(exp_hits(words[i], 1)))
        begin n_fail++; $display("FAIL sat_hits word %h got %0d want %0d", words[i], if1.out_hits, exp_hits(words[i], 1)); end
      n_checks++; if (if1.out_sat !== exp_sat(words[i], 1))
        begin n_fail++; $display("FAIL sat_flag word %h got %b want %b", words[i], if1.out_sat, exp_sat(words[i], 1)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [3:0] h; logic s; logic [7:0] bits; logic to;
    logic [7:0] w;
    w = 8'($urandom);
    if4.out_ready = 1'b0;
    run_word4(w, lat, h, s, bits, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b want 0", to); end
    n_checks++; if (h !== 4'(exp_hits(w, 4))) begin n_fail++; $display("FAIL bp_hits word %h got %0d want %0d", w, h, exp_hits(w, 4)); end
    for (int k = 0; k < 5; k++) begin
      if4.in_valid = (k % 2 == 0);
      if4.in_data  = ~w;
      @(posedge clk); #1;
      n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc %0d got %b want 1", k, if4.out_valid); end
      n_checks++; if (if4.out_hits !== h)     begin n_fail++; $display("FAIL bp_hits_stable cyc %0d got %0d want %0d", k, if4.out_hits, h); end
      n_checks++; if (if4.in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", k, if4.in_ready); end
      n_checks++; if (if4.det_rst !== 1'b1)   begin n_fail++; $display("FAIL bp_det_rst cyc %0d got %b want 1", k, if4.det_rst); end
    end
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", if4.out_valid); end
    n_checks++; if (if4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_ready got %b want 1", if4.in_ready); end
    @(posedge clk); #1;
    n_checks++; if (if4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_no_ghost_accept got %b want 1", if4.in_ready); end
  endtask

  task automatic test_reset_midword;
    int   n;
    int   seen;
    logic rdy;
    int lat; logic [3:0] h; logic s; logic [7:0] bits; logic to;
    if4.in_data  = 8'hAA;
    if4.in_valid = 1'b1;
    n = 0;
    do begin
      rdy = if4.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 40);
    if4.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (if4.det_rst !== 1'b0) begin n_fail++; $display("FAIL midrst_shifting got det_rst %b want 0", if4.det_rst); end
    n_checks++; if (if4.det_in !== 1'b0)  begin n_fail++; $display("FAIL midrst_bit4 got %b want 0", if4.det_in); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (if4.in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", if4.in_ready); end
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", if4.out_valid); end
    n_checks++; if (if4.det_rst !== 1'b1)   begin n_fail++; $display("FAIL midrst_det_rst got %b want 1", if4.det_rst); end
    n_checks++; if (if4.det_in !== 1'b0)    begin n_fail++; $display("FAIL midrst_det_in got %b want 0", if4.det_in); end
    n_checks++; if (if4.out_hits !== 4'd0)  begin n_fail++; $display("FAIL midrst_out_hits got %0d want 0", if4.out_hits); end
    n_checks++; if (if4.out_sat !== 1'b0)   begin n_fail++; $display("FAIL midrst_out_sat got %b want 0", if4.out_sat); end
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    repeat (12) begin
      if (if4.out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_result_lost got %0d valid cycles want 0", seen); end
    run_word4(8'b00000101, lat, h, s, bits, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL midrst_next_timeout got %b want 0", to); end
    n_checks++; if (h !== 4'd1)  begin n_fail++; $display("FAIL midrst_next_hits got %0d want 1", h); end
  endtask

  task automatic test_random;
    logic [7:0] w;
    int lat; logic [3:0] h; logic s; logic [7:0] bits; logic to;
    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom);
      run_word4(w, lat, h, s, bits, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand_timeout word %h got %b want 0", w, to); end
      n_checks++; if (bits !== w)  begin n_fail++; $display("FAIL rand_det_in_seq got %b want %b", bits, w); end
      n_checks++; if (lat != 9)    begin n_fail++; $display("FAIL rand_latency word %h got %0d want 9", w, lat); end
      n_checks++; if (h !== 4'(exp_hits(w, 4)))
        begin n_fail++; $display("FAIL rand_hits word %h got %0d want %0d", w, h, exp_hits(w, 4)); end
      n_checks++; if (s !== exp_sat(w, 4))
        begin n_fail++; $display("FAIL rand_sat word %h got %b want %b", w, s, exp_sat(w, 4)); end
    end
  endtask

  task automatic test_continuous;
    logic [7:0] words [6];
    logic [7:0] exp_q [$];
    logic [7:0] w;
    int   n_acc, n_res, cyc, last_acc;
    logic acc;
    for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
    n_acc = 0; n_res = 0; cyc = 0; last_acc = 0;
    if4.out_ready = 1'b1;
    if4.in_data   = words[0];
    if4.in_valid  = 1'b1;
    while (n_res < 6 && cyc < 200) begin
      acc = if4.in_valid && if4.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (n_acc > 0) begin
          n_checks++; if (cyc - last_acc != 11)
            begin n_fail++; $display("FAIL cont_period word %0d got %0d want 11", n_acc, cyc - last_acc); end
        end
        last_acc = cyc;
        exp_q.push_back(words[n_acc]);
        n_acc++;
        if (n_acc < 6) if4.in_data = words[n_acc];
        else           if4.in_valid = 1'b0;
      end
      if (if4.out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL cont_extra_result got hits %0d want none", if4.out_hits);
        end else begin
          w = exp_q.pop_front();
          if (if4.out_hits !== 4'(exp_hits(w, 4)))
            begin n_fail++; $display("FAIL cont_hits word %h got %0d want %0d", w, if4.out_hits, exp_hits(w, 4)); end
        end
        n_res++;
      end
    end
    if4.in_valid = 1'b0;
    n_checks++; if (n_res != 6) begin n_fail++; $display("FAIL cont_results got %0d want 6", n_res); end
    n_checks++; if (n_acc != 6) begin n_fail++; $display("FAIL cont_accepts got %0d want 6", n_acc); end
    repeat (15) begin
      @(posedge clk); #1;
      n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL cont_duplicate got out_valid %b want 0", if4.out_valid); end
    end
  endtask

  initial begin
    if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b1;
    test_reset;
    test_basic;
    test_back_to_back;
    test_saturation;
    test_backpressure;
    test_reset_midword;
    test_random;
    test_continuous;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
